counter_run_ctrl: RTL and testbench
===================================

// Module: counter_run_ctrl
// PURPOSE
//  Run controller for the 4-bit clock_counter datapath. Drives the counter's rst/en pins.
//  On a start command it clears the counter and enables it until the counter value reaches
//  a captured target. It also supports pause, abort and an optional stall watchdog.
//  Sits between the top-level control (buttons/regs) and the counter instance.
// PARAMETERS
//  CNT_W           4         width of target / cnt_val (matches counter output)
//  TIMEOUT_CYCLES  40000000  RUN cycles without a cnt_val change before timeout (watchdog only)
// PORTS
//  clk          in   1      single clock; all logic posedge clk
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      request run; sampled only in IDLE
//  stop         in   1      abort; honoured in CLEAR, RUN, HALT
//  pause        in   1      level; high in RUN -> HALT, low in HALT -> RUN
//  target       in   CNT_W  stop value; captured into target_q when start accepted
//  cnt_val      in   CNT_W  counter output, fed back from clock_counter.out
//  cnt_rst      out  1      active-high clear to counter rst
//  cnt_en       out  1      counter enable
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle completion pulse
//  timeout_err  out  1      sticky watchdog error (0 when feature compiled out)
//  state        out  2      IDLE=0, CLEAR=1, RUN=2, HALT=3
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; target_q=0, prev_val=0, stepped=0; all outputs 0.
//  - cnt_rst = (state==CLEAR); cnt_en = (state==RUN); busy = (state!=IDLE). All decoded from state reg.
//  - IDLE: start & !stop -> CLEAR; target_q<=target, stepped<=0, timeout_err<=0. start&stop -> stay IDLE.
//  - CLEAR: exactly 1 cycle. stop -> IDLE, else -> RUN. Latency: start at N, cnt_rst high N+1, cnt_en high N+2.
//  - RUN, priority: stop -> IDLE (no done); complete -> IDLE, done=1 next cycle; pause -> HALT.
//  - HALT: stop -> IDLE (no done); !pause -> RUN; cnt_en low, counter frozen.
//  - prev_val<=cnt_val every cycle. stepped<=1 when in RUN and cnt_val!=prev_val.
//  - complete = stepped & (cnt_val==target_q), evaluated in RUN only.
//  - stepped guard: target_q=0 runs the full 16-step wrap 15->0, not an instant completion.
//  - done: registered pulse, high for exactly the first IDLE cycle after a completion; never on abort or timeout.
//  - start while busy: ignored; target_q unchanged.
//  - Reset mid-run: immediate return to IDLE next edge; cnt_en drops, no done.
//  - Counter wrap 15->0 is a normal step; compare is on full CNT_W bits, no arithmetic on cnt_val.
// CONFIGURATION
//  COUNTER_TIMEOUT_EN defined:
//   - 32-bit wd counter: cleared on entering RUN and on any cnt_val change; increments each RUN cycle;
//     held in HALT.
//   - wd==TIMEOUT_CYCLES-1 in RUN (and not completing, not stop) -> timeout_err<=1, state -> IDLE, no done.
//   - timeout_err stays 1 until the next accepted start or reset.
//  COUNTER_TIMEOUT_EN undefined: no wd logic; timeout_err tied 0; the port is still present.
// TESTING (bench uses a behavioural counter model: +1 every 4 en-high cycles, clear on rst)
//  1 rst_n=0 for 2 cycles -> state=0, cnt_en=0, cnt_rst=0, busy=0, done=0, timeout_err=0.
//  2 start with target=3 at cycle N -> cnt_rst=1 at N+1 only; cnt_en=1 from N+2;
//    cnt_val reaches 3 -> cnt_en=0 next cycle, single done pulse, cnt_val holds 3.
//  3 target=0 -> 16 steps, done only after the 15->0 wrap; 4 start+stop same cycle -> stays IDLE.
//  4 pause=1 for 10 cycles mid-RUN -> state=3, cnt_en=0, cnt_val frozen; pause=0 -> RUN resumes;
//    then stop=1 -> IDLE, no done.
//  5 start with target=9 while busy (target_q=5) -> ignored; run completes at cnt_val=5.
//  6 COUNTER_TIMEOUT_EN, TIMEOUT_CYCLES=20, model stuck -> timeout_err=1 after 20 RUN cycles, IDLE, no done;
//    next start clears timeout_err.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Run controller for the 4-bit clock_counter: clears it, enables it until it reaches a captured
// target, and supports pause/abort. Optional stall watchdog compiled in with COUNTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start; counter held (en low)
// CLEAR  | one-cycle counter clear (cnt_rst high)
// RUN    | counter enabled until cnt_val reaches target_q
// HALT   | paused; counter frozen until pause drops
module counter_run_ctrl #(
   parameter int CNT_W          = 4,
   parameter int TIMEOUT_CYCLES = 40000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [CNT_W-1:0] target,
   input  logic [CNT_W-1:0] cnt_val,
   output logic             cnt_rst,
   output logic             cnt_en,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] prev_val_q, prev_val_d;
   logic             stepped_q, stepped_d;
   logic             done_q, done_d;
   logic             timeout_err_q, timeout_err_d;
   logic             start_ok, changed, complete, wd_expire;

   assign start_ok = (state_q == S_IDLE) && start && !stop;
   assign changed  = (cnt_val != prev_val_q);
   // stepped blocks an instant completion when target_q equals the freshly cleared value
   assign complete = (state_q == S_RUN) && stepped_q && (cnt_val == target_q);

`ifdef COUNTER_TIMEOUT_EN
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] wd_q, wd_d;

   assign wd_expire = (state_q == S_RUN) && (wd_q == WD_LAST) && !complete && !stop;

   always_comb begin
      wd_d = wd_q;
      if ((state_d == S_RUN) && (state_q != S_RUN)) begin
         wd_d = '0;
      end else if (changed) begin
         wd_d = '0;
      end else if (state_q == S_RUN) begin
         wd_d = wd_q + 32'd1;
      end
   end

   always_comb begin
      timeout_err_d = timeout_err_q;
      if (start_ok) begin
         timeout_err_d = 1'b0;
      end else if (wd_expire) begin
         timeout_err_d = 1'b1;
      end
   end
`else
   assign wd_expire     = 1'b0;
   assign timeout_err_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         target_q      <= '0;
         prev_val_q    <= '0;
         stepped_q     <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef COUNTER_TIMEOUT_EN
         wd_q          <= '0;
`endif
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         prev_val_q    <= prev_val_d;
         stepped_q     <= stepped_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
`ifdef COUNTER_TIMEOUT_EN
         wd_q          <= wd_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      prev_val_d = cnt_val;
      stepped_d  = stepped_q;
      done_d     = complete && !stop;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d   = S_CLEAR;
               target_d  = target;
               stepped_d = 1'b0;
            end
         end
         S_CLEAR: state_d = stop ? S_IDLE : S_RUN;
         S_RUN: begin
            if (changed) stepped_d = 1'b1;
            if (stop || complete || wd_expire) begin
               state_d = S_IDLE;
            end else if (pause) begin
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (!pause) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_rst     = (state_q == S_CLEAR);
      cnt_en      = (state_q == S_RUN);
      busy        = (state_q != S_IDLE);
      done        = done_q;
      timeout_err = timeout_err_q;
      state       = state_q;
   end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl with a behavioural clock_counter (+1 per 4 enabled cycles).
module tb_counter_run_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] target = 4'd0;
   logic [3:0] cnt_val;
   logic [1:0] div;
   logic       stuck = 1'b0;
   logic       cnt_rst, cnt_en, busy, done, timeout_err;
   logic [1:0] state;

   int checks = 0;
   int failures = 0;

   counter_run_ctrl #(.CNT_W(4), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .target(target), .cnt_val(cnt_val), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
      .busy(busy), .done(done), .timeout_err(timeout_err), .state(state)
   );

   always #5 clk = ~clk;

   // Counter model: synchronous clear, steps once every four enabled cycles.
   always @(posedge clk) begin
      if (!rst_n || cnt_rst) begin
         cnt_val <= 4'd0;
         div     <= 2'd0;
      end else if (cnt_en && !stuck) begin
         if (div == 2'd3) begin
            div     <= 2'd0;
            cnt_val <= cnt_val + 4'd1;
         end else begin
            div <= div + 2'd1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; target = 4'd6;
      tick(); tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (cnt_en !== 1'b0) begin failures++; $display("FAIL reset_cnt_en: got %b expected 0", cnt_en); end
      checks++; if (cnt_rst !== 1'b0) begin failures++; $display("FAIL reset_cnt_rst: got %b expected 0", cnt_rst); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      rst_n = 1'b1; start = 1'b0;
   endtask

   // Full run to completion. Reference: a target t needs s = (t==0 ? 16 : t) counter steps, each
   // four enabled cycles, plus the compare cycle -> 4*s+1 enabled cycles, pauses adding only HALT time.
   task automatic run_target(input int t, input int pause_at, input int pause_len,
                             input int restart_at, input string name);
      int steps, exp_en, en_cnt, halt_cnt, early_done, bad_halt, bad_rst;
      logic fin;
      logic [3:0] frozen;
      steps = (t == 0) ? 16 : t;
      exp_en = 4 * steps + 1;
      target = t[3:0]; start = 1'b1;
      tick();
      start = 1'b0; target = 4'($urandom);
      checks++; if (state !== 2'd1 || cnt_rst !== 1'b1 || cnt_en !== 1'b0 || busy !== 1'b1)
         begin failures++; $display("FAIL %s clear_cycle: got state=%0d rst=%b en=%b busy=%b expected 1/1/0/1", name, state, cnt_rst, cnt_en, busy); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL %s start_clears_err: got %b expected 0", name, timeout_err); end
      tick();
      checks++; if (state !== 2'd2 || cnt_rst !== 1'b0 || cnt_en !== 1'b1 || cnt_val !== 4'd0)
         begin failures++; $display("FAIL %s run_entry: got state=%0d rst=%b en=%b val=%0d expected 2/0/1/0", name, state, cnt_rst, cnt_en, cnt_val); end
      en_cnt = 1; halt_cnt = 0; fin = 1'b0; early_done = 0; bad_halt = 0; bad_rst = 0; frozen = 4'd0;
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         pause = (pause_at != 0) && (en_cnt >= pause_at) && (halt_cnt < pause_len);
         if (restart_at != 0 && en_cnt == restart_at && state == 2'd2) begin
            start = 1'b1; target = 4'd9;
         end
         tick();
         start = 1'b0;
         if (cnt_rst) bad_rst++;
         if (state == 2'd0) begin
            fin = 1'b1;
         end else begin
            if (done) early_done++;
            if (state == 2'd3) begin
               if (halt_cnt == 0) frozen = cnt_val;
               else if (cnt_val != frozen || cnt_en) bad_halt++;
               halt_cnt++;
            end else if (state == 2'd2) begin
               en_cnt++;
            end
         end
      end
      pause = 1'b0;
      checks++; if (fin !== 1'b1) begin failures++; $display("FAIL %s finish_bound: got fin=%b expected 1", name, fin); end
      checks++; if (en_cnt != exp_en) begin failures++; $display("FAIL %s en_cycles: got %0d expected %0d", name, en_cnt, exp_en); end
      checks++; if (halt_cnt != ((pause_at != 0) ? pause_len : 0)) begin failures++; $display("FAIL %s halt_cycles: got %0d expected %0d", name, halt_cnt, (pause_at != 0) ? pause_len : 0); end
      checks++; if (bad_halt != 0 || bad_rst != 0 || early_done != 0) begin failures++; $display("FAIL %s run_body: got bad_halt=%0d bad_rst=%0d early_done=%0d expected 0", name, bad_halt, bad_rst, early_done); end
      checks++; if (done !== 1'b1 || busy !== 1'b0 || cnt_en !== 1'b0) begin failures++; $display("FAIL %s done_pulse: got done=%b busy=%b en=%b expected 1/0/0", name, done, busy, cnt_en); end
      checks++; if (cnt_val !== t[3:0]) begin failures++; $display("FAIL %s final_val: got %0d expected %0d", name, cnt_val, t); end
      tick();
      checks++; if (done !== 1'b0 || cnt_val !== t[3:0]) begin failures++; $display("FAIL %s after_done: got done=%b val=%0d expected 0/%0d", name, done, cnt_val, t); end
   endtask

   task automatic test_start_stop();
      target = 4'd7; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      checks++; if (state !== 2'd0 || busy !== 1'b0 || cnt_rst !== 1'b0) begin failures++; $display("FAIL start_stop_same: got state=%0d busy=%b rst=%b expected 0/0/0", state, busy, cnt_rst); end
      start = 1'b1;
      tick();
      start = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd0 || cnt_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stop_in_clear: got state=%0d en=%b done=%b expected 0/0/0", state, cnt_en, done); end
   endtask

   task automatic test_pause_stop();
      logic [3:0] frozen;
      int bad;
      target = 4'd12; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick(); tick(); tick();
      pause = 1'b1;
      tick();
      checks++; if (state !== 2'd3 || cnt_en !== 1'b0) begin failures++; $display("FAIL pause_enter: got state=%0d en=%b expected 3/0", state, cnt_en); end
      frozen = cnt_val; bad = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (state != 2'd3 || cnt_en || cnt_val != frozen) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
      pause = 1'b0;
      tick();
      checks++; if (state !== 2'd2 || cnt_en !== 1'b1) begin failures++; $display("FAIL pause_resume: got state=%0d en=%b expected 2/1", state, cnt_en); end
      tick(); tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd0 || cnt_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL run_abort: got state=%0d en=%b done=%b expected 0/0/0", state, cnt_en, done); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_no_done: got %b expected 0", done); end
   endtask

   task automatic test_reset_midrun();
      target = 4'd10; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      checks++; if (state !== 2'd0 || cnt_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_midrun: got state=%0d en=%b busy=%b done=%b expected 0/0/0/0", state, cnt_en, busy, done); end
      rst_n = 1'b1;
      tick();
      checks++; if (done !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL reset_midrun_after: got done=%b state=%0d expected 0/0", done, state); end
   endtask

   task automatic test_watchdog();
      int en_cnt;
      do_reset();
      stuck = 1'b1;
      target = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      en_cnt = (state == 2'd2) ? 1 : 0;
`ifdef COUNTER_TIMEOUT_EN
      for (int i = 0; i < 100 && state == 2'd2; i++) begin
         tick();
         if (state == 2'd2) en_cnt++;
      end
      checks++; if (en_cnt != 20) begin failures++; $display("FAIL wd_run_cycles: got %0d expected 20", en_cnt); end
      checks++; if (state !== 2'd0 || timeout_err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wd_trip: got state=%0d err=%b done=%b expected 0/1/0", state, timeout_err, done); end
      tick();
      checks++; if (timeout_err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wd_sticky: got err=%b done=%b expected 1/0", timeout_err, done); end
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         if (state == 2'd2 && timeout_err == 1'b0) en_cnt++;
      end
      checks++; if (en_cnt != 41) begin failures++; $display("FAIL nowd_stall: got %0d clean RUN cycles expected 41", en_cnt); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd0 || done !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL nowd_abort: got state=%0d done=%b err=%b expected 0/0/0", state, done, timeout_err); end
`endif
      stuck = 1'b0;
      run_target(2, 0, 0, 0, "after_stall");
   endtask

   task automatic test_random();
      int t, pa, pl;
      for (int i = 0; i < 8; i++) begin
         t  = int'($urandom_range(2, 15));
         pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * t - 1)) : 0;
         pl = int'($urandom_range(1, 6));
         run_target(t, pa, pl, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      run_target(0, 20, 3, 0, "target0_wrap");
      run_target(3, 0, 0, 0, "basic_t3");
      test_start_stop();
      test_pause_stop();
      run_target(5, 0, 0, 7, "busy_start");
      test_reset_midrun();
      test_watchdog();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
